muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, ports as listed below.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid / req_ready  in / out  1 / 1  operation handshake.
REQ-005 req_is_div  in  1  0=multiply, 1=divide.
REQ-006 req_sign  in  1  signed operation when 1.
REQ-007 req_a / req_b  in  32 / 32  source operands (dividend / divisor).
REQ-008 flush  in  1  cancels any in-flight operation.
REQ-009 unit_start  out  1  one-cycle launch pulse to the iterative mul/div unit.
REQ-010 unit_is_div / unit_sign / unit_a / unit_b  out  1 / 1 / 32 / 32  latched operands driven to the unit.
REQ-011 unit_abort  out  1  one-cycle cancel pulse to the unit.
REQ-012 unit_done / unit_hi / unit_lo  in  1 / 32 / 32  unit completion and results.
REQ-013 rd_hi / rd_lo  in  1 / 1  MFHI/MFLO read request from the pipeline.
REQ-014 wr_hi / wr_lo / wr_data  in  1 / 1 / 32  MTHI/MTLO write.
REQ-015 hi / lo  out  32 / 32  architectural HI/LO registers.
REQ-016 busy / stall  out  1 / 1  operation in flight / pipeline hold.
REQ-017 dz_flag / tmo_flag  out  1 / 1  one-cycle divide-by-zero / timeout pulses.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT and COMMIT; busy SHALL be 1 in every state except IDLE.
REQ-019 req_ready SHALL equal (state==IDLE); a request SHALL be accepted on req_valid & req_ready & ~flush.
REQ-020 On acceptance of a divide with req_b==0, the block SHALL stay in IDLE, pulse dz_flag for one cycle, and leave hi/lo unchanged.
REQ-021 On any other acceptance, the block SHALL latch the op, sign and operands into unit_* and go to LAUNCH.
REQ-022 unit_* outputs SHALL hold their values from acceptance until the next acceptance.
REQ-023 In LAUNCH, unit_start SHALL be 1 for exactly one cycle, the 6-bit wait counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-024 In WAIT with unit_done==1, the block SHALL latch unit_hi/unit_lo into result registers and go to COMMIT.
REQ-025 In WAIT with unit_done==0, the counter SHALL increment.
REQ-026 When the counter reaches 63 without unit_done, the block SHALL pulse tmo_flag and unit_abort, go to IDLE, and not write hi/lo.
REQ-027 In COMMIT, the block SHALL write both hi and lo from the result registers and go to IDLE; new values SHALL be visible the cycle after COMMIT.
REQ-028 Minimum latency from acceptance to hi/lo update SHALL be 4 edges when unit_done is returned in the first WAIT cycle.
REQ-029 flush in LAUNCH or WAIT SHALL force IDLE next cycle, pulse unit_abort, and suppress unit_start if it was not yet issued; hi/lo SHALL be unchanged.
REQ-030 flush in COMMIT SHALL be ignored; the commit SHALL complete.
REQ-031 flush in IDLE SHALL block acceptance in that cycle.
REQ-032 unit_done outside WAIT SHALL be ignored.
REQ-033 stall SHALL equal busy & (rd_hi | rd_lo | wr_hi | wr_lo).
REQ-034 While busy, wr_hi/wr_lo SHALL NOT modify hi/lo.
REQ-035 In IDLE, wr_hi SHALL write wr_data to hi and wr_lo SHALL write wr_data to lo on the edge; both MAY assert together.
REQ-036 A same-cycle accept plus wr_hi in IDLE SHALL apply the write; the later COMMIT SHALL overwrite it.
REQ-037 All outputs SHALL be registered except req_ready, stall and busy, which are decoded combinationally from state and inputs.

Reset
REQ-038 rst_n low SHALL asynchronously force: state IDLE, hi/lo/result registers 0, wait counter 0, unit_a/unit_b 0, and unit_start, unit_abort, dz_flag, tmo_flag, unit_is_div and unit_sign all 0.
REQ-039 Reset mid-operation SHALL discard the operation without a unit_abort pulse; the unit is reset by the same rst_n.
REQ-040 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-041 Unsigned multiply: accept mul, a=0xFFFFFFFF, b=2; unit model returns done after 5 cycles with hi=0x00000001, lo=0xFFFFFFFE -> hi/lo take those values the cycle after COMMIT; exactly one unit_start.
REQ-042 Divide by zero: accept div, a=7, b=0 -> dz_flag pulses once, no unit_start, hi/lo retain prior 0x12345678/0x9ABCDEF0.
REQ-043 Flush: flush asserted in the 3rd WAIT cycle -> unit_abort one-cycle pulse, state IDLE, hi/lo unchanged, late unit_done ignored.
REQ-044 Timeout: unit never asserts done -> tmo_flag and unit_abort pulse 64 cycles after LAUNCH, busy drops, hi/lo unchanged.
REQ-045 Hazard: rd_lo held during an operation -> stall=1 every busy cycle, stall=0 the cycle after COMMIT, lo equals the new result.
REQ-046 Write blocking: wr_hi with wr_data=0xCAFEBABE while busy -> stall=1 and hi unchanged.
REQ-047 Write in IDLE: the same wr_hi in IDLE -> hi=0xCAFEBABE next cycle.
REQ-048 Reset mid-op: rst_n low during WAIT -> immediate IDLE, hi=lo=0, and req_ready=1 after release.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Request channel between the pipeline and the mul/div controller.
// The pipeline side is the master, the controller is the slave.
interface muldiv_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_div;
    logic              req_sign;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    modport master (
        output req_valid, req_is_div, req_sign, req_a, req_b,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_is_div, req_sign, req_a, req_b,
        output req_ready
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for an iterative multiply/divide unit.
// Accepts one operation at a time, launches the unit, waits for completion
// (bounded by a 64-cycle watchdog), then commits the result into the
// architectural HI/LO pair. Also arbitrates MTHI/MTLO writes and raises a
// pipeline stall for HI/LO accesses while an operation is in flight.
module muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_ctrl_if.slave      req,
    input  logic              flush,
    output logic              unit_start,
    output logic              unit_is_div,
    output logic              unit_sign,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic              unit_abort,
    input  logic              unit_done,
    input  logic [DATA_W-1:0] unit_hi,
    input  logic [DATA_W-1:0] unit_lo,
    input  logic              rd_hi,
    input  logic              rd_lo,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              stall,
    output logic              dz_flag,
    output logic              tmo_flag
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Last counter value before the watchdog fires (64 WAIT cycles total).
    localparam logic [5:0] TMO_LAST = 6'd63;

    state_t            state_q;
    logic [5:0]        cnt_q;
    logic              unit_start_q;
    logic              unit_abort_q;
    logic              unit_is_div_q;
    logic              unit_sign_q;
    logic [DATA_W-1:0] unit_a_q;
    logic [DATA_W-1:0] unit_b_q;
    logic              dz_q;
    logic              tmo_q;
    logic [DATA_W-1:0] res_hi_q;
    logic [DATA_W-1:0] res_lo_q;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic accept;
    logic div_zero;

    // A flush in the same cycle as a request blocks acceptance.
    assign accept   = req.req_valid && (state_q == S_IDLE) && !flush;
    assign div_zero = req.req_is_div && (req.req_b == '0);

    assign req.req_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign stall         = busy && (rd_hi || rd_lo || wr_hi || wr_lo);

    assign unit_start  = unit_start_q;
    assign unit_abort  = unit_abort_q;
    assign unit_is_div = unit_is_div_q;
    assign unit_sign   = unit_sign_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign dz_flag     = dz_q;
    assign tmo_flag    = tmo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Operation FSM with registered launch/abort/flag pulses and operand latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            unit_start_q  <= 1'b0;
            unit_abort_q  <= 1'b0;
            unit_is_div_q <= 1'b0;
            unit_sign_q   <= 1'b0;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            dz_q          <= 1'b0;
            tmo_q         <= 1'b0;
            res_hi_q      <= '0;
            res_lo_q      <= '0;
        end else begin
            unit_start_q <= 1'b0;
            unit_abort_q <= 1'b0;
            dz_q         <= 1'b0;
            tmo_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            // Never reaches the unit; HI/LO are left alone.
                            dz_q <= 1'b1;
                        end else begin
                            unit_is_div_q <= req.req_is_div;
                            unit_sign_q   <= req.req_sign;
                            unit_a_q      <= req.req_a;
                            unit_b_q      <= req.req_b;
                            state_q       <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (flush) begin
                        // Start has not gone out yet, so only the abort is sent.
                        unit_abort_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        unit_start_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        unit_abort_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else if (unit_done) begin
                        res_hi_q <= unit_hi;
                        res_lo_q <= unit_lo;
                        state_q  <= S_COMMIT;
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_q        <= 1'b1;
                        unit_abort_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_COMMIT: begin
                    // Flush is deliberately ignored here: the result is final.
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // HI/LO next value: commit wins; MTHI/MTLO only take effect while idle.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_COMMIT) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
        end else if (state_q == S_IDLE) begin
            if (wr_hi) hi_d = wr_data;
            if (wr_lo) lo_d = wr_data;
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: inputs change 1ns after the rising edge,
// outputs are examined before the next rising edge.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        unit_start, unit_is_div, unit_sign, unit_abort;
    logic [31:0] unit_a, unit_b;
    logic        unit_done;
    logic [31:0] unit_hi, unit_lo;
    logic        rd_hi, rd_lo, wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic [31:0] hi, lo;
    logic        busy, stall, dz_flag, tmo_flag;

    muldiv_ctrl_if #(.DATA_W(32)) bus ();

    muldiv_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (bus),
        .flush      (flush),
        .unit_start (unit_start),
        .unit_is_div(unit_is_div),
        .unit_sign  (unit_sign),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_abort (unit_abort),
        .unit_done  (unit_done),
        .unit_hi    (unit_hi),
        .unit_lo    (unit_lo),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wr_data    (wr_data),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall),
        .dz_flag    (dz_flag),
        .tmo_flag   (tmo_flag)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    int n_abort = 0;
    int n_dz = 0;
    int n_tmo = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (unit_start) n_start++;
        if (unit_abort) n_abort++;
        if (dz_flag)    n_dz++;
        if (tmo_flag)   n_tmo++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic is_div, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid  = 1'b1;
        bus.req_is_div = is_div;
        bus.req_sign   = sgn;
        bus.req_a      = a;
        bus.req_b      = b;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    int s0, a0, d0, t0, k;

    initial begin
        rst_n = 1'b0; flush = 1'b0; unit_done = 1'b0; unit_hi = '0; unit_lo = '0;
        rd_hi = 1'b0; rd_lo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        bus.req_valid = 1'b0; bus.req_is_div = 1'b0; bus.req_sign = 1'b0;
        bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  busy, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_hi",    hi, 0);
        check("rst_lo",    lo, 0);
        check("rst_ua",    unit_a, 0);

        // Unsigned multiply accepted on first edge after reset release.
        rst_nReleaseAndMul();

        // MTHI / MTLO in idle.
        wr_hi = 1'b1; wr_data = 32'h12345678; tick();
        wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h9ABCDEF0; tick();
        wr_lo = 1'b0;
        check("mthi_idle", hi, 32'h12345678);
        check("mtlo_idle", lo, 32'h9ABCDEF0);

        // Divide by zero.
        s0 = n_start; d0 = n_dz;
        issue(1'b1, 1'b0, 32'd7, 32'd0);
        check("dz_pulse", dz_flag, 1);
        check("dz_busy",  busy, 0);
        tick();
        check("dz_clear", dz_flag, 0);
        check("dz_count", n_dz - d0, 1);
        check("dz_nostart", n_start - s0, 0);
        check("dz_hi", hi, 32'h12345678);
        check("dz_lo", lo, 32'h9ABCDEF0);

        // Flush in idle blocks acceptance.
        bus.req_valid = 1'b1; bus.req_is_div = 1'b0; flush = 1'b1;
        tick();
        bus.req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", busy, 0);

        // Flush in LAUNCH: abort, no start.
        s0 = n_start; a0 = n_abort;
        issue(1'b0, 1'b1, 32'd3, 32'd5);
        check("fl_launch_usign", unit_sign, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("fl_launch_abort", unit_abort, 1);
        check("fl_launch_busy",  busy, 0);
        tick();
        check("fl_launch_nostart", n_start - s0, 0);
        check("fl_launch_abcnt",   n_abort - a0, 1);

        // Flush in the third WAIT cycle; a late done is ignored.
        a0 = n_abort;
        issue(1'b0, 1'b0, 32'd3, 32'd5);
        tick(); tick(); tick();
        check("fl_wait_busy_pre", busy, 1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("fl_wait_abort", unit_abort, 1);
        check("fl_wait_ready", bus.req_ready, 1);
        unit_done = 1'b1; unit_hi = 32'hDEAD0000; unit_lo = 32'h0000BEEF;
        tick();
        unit_done = 1'b0;
        check("fl_wait_abort_1cyc", unit_abort, 0);
        check("fl_wait_late_busy", busy, 0);
        tick();
        check("fl_wait_hi", hi, 32'h12345678);
        check("fl_wait_lo", lo, 32'h9ABCDEF0);
        check("fl_wait_abcnt", n_abort - a0, 1);

        // Timeout: done never arrives.
        t0 = n_tmo;
        issue(1'b1, 1'b0, 32'd100, 32'd7);
        tick();
        k = 0;
        while (tmo_flag !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("tmo_latency", k, 64);
        check("tmo_abort", unit_abort, 1);
        check("tmo_busy",  busy, 0);
        tick();
        check("tmo_count", n_tmo - t0, 1);
        check("tmo_hi", hi, 32'h12345678);
        check("tmo_lo", lo, 32'h9ABCDEF0);

        // Hazard stall with rd_lo held, plus blocked MTHI while busy.
        rd_lo = 1'b1;
        check("haz_idle_stall", stall, 0);
        issue(1'b0, 1'b0, 32'd10, 32'd20);
        check("haz_launch_stall", stall, 1);
        wr_hi = 1'b1; wr_data = 32'hCAFEBABE;
        tick();
        check("haz_wait_stall", stall, 1);
        check("haz_wr_blocked", hi, 32'h12345678);
        unit_done = 1'b1; unit_hi = 32'hAAAA0001; unit_lo = 32'hBBBB0002;
        tick();
        unit_done = 1'b0;
        check("haz_commit_stall", stall, 1);
        check("haz_commit_hi_old", hi, 32'h12345678);
        tick();
        check("haz_after_stall", stall, 0);
        check("haz_lo_new", lo, 32'hBBBB0002);
        check("haz_hi_new", hi, 32'hAAAA0001);
        tick();
        check("mthi_idle_cafe", hi, 32'hCAFEBABE);
        wr_hi = 1'b0; rd_lo = 1'b0;

        // Done outside WAIT is ignored.
        unit_done = 1'b1; unit_hi = 32'h0BAD0BAD; unit_lo = 32'h0BAD0BAD;
        tick();
        unit_done = 1'b0;
        check("done_idle_busy", busy, 0);
        check("done_idle_lo", lo, 32'hBBBB0002);

        // Accept + MTHI in the same cycle, minimum latency commit overwrites.
        wr_hi = 1'b1; wr_data = 32'h11112222;
        issue(1'b1, 1'b1, 32'd50, 32'd3);
        wr_hi = 1'b0;
        check("acc_wr_hi", hi, 32'h11112222);
        check("acc_wr_udiv", unit_is_div, 1);
        tick();
        unit_done = 1'b1; unit_hi = 32'h33334444; unit_lo = 32'h55556666;
        tick();
        unit_done = 1'b0;
        check("minlat_pre", hi, 32'h11112222);
        tick();
        check("minlat_hi", hi, 32'h33334444);
        check("minlat_lo", lo, 32'h55556666);
        check("minlat_ua", unit_a, 32'd50);

        // Reset in the middle of an operation.
        a0 = n_abort;
        issue(1'b0, 1'b0, 32'd9, 32'd9);
        tick(); tick();
        check("rmid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rmid_busy", busy, 0);
        check("rmid_hi", hi, 0);
        check("rmid_lo", lo, 0);
        check("rmid_abort", unit_abort, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rmid_ready", bus.req_ready, 1);
        check("rmid_abcnt", n_abort - a0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    task automatic rst_nReleaseAndMul();
        int s_before;
        s_before = n_start;
        rst_n = 1'b1;
        issue(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2);
        check("mul_accept_busy", busy, 1);
        check("mul_ua", unit_a, 32'hFFFFFFFF);
        check("mul_ub", unit_b, 32'd2);
        check("mul_launch_nostart", unit_start, 0);
        tick();
        check("mul_start", unit_start, 1);
        repeat (4) tick();
        check("mul_start_once", unit_start, 0);
        unit_done = 1'b1; unit_hi = 32'h00000001; unit_lo = 32'hFFFFFFFE;
        tick();
        unit_done = 1'b0;
        check("mul_commit_hi_old", hi, 0);
        check("mul_commit_busy", busy, 1);
        tick();
        check("mul_hi", hi, 32'h00000001);
        check("mul_lo", lo, 32'hFFFFFFFE);
        check("mul_idle", busy, 0);
        check("mul_nstart", n_start - s_before, 1);
    endtask

endmodule
